sram_arbiter: RTL

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter_pkg.sv | 14 +
 rtl/sram_arbiter_if.sv | 49 ++++
 rtl/sram_arb_grant.sv | 32 +++
 rtl/sram_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/sram_arbiter_pkg.sv
// Shared definitions for the two-port SRAM arbiter: default widths and FSM state encoding.
package sram_arbiter_pkg;

    localparam int ADDR_W_DEFAULT  = 18;
    localparam int WDATA_W_DEFAULT = 32;
    localparam int RDATA_W_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Bus bundle for the SRAM arbiter: two requester ports plus the SRAM-controller command/response.
interface sram_arbiter_if #(
    parameter int ADDR_W  = sram_arbiter_pkg::ADDR_W_DEFAULT,
    parameter int WDATA_W = sram_arbiter_pkg::WDATA_W_DEFAULT,
    parameter int RDATA_W = sram_arbiter_pkg::RDATA_W_DEFAULT
) ();

    logic [ADDR_W-1:0]  p0_address;
    logic [WDATA_W-1:0] p0_wdata;
    logic               p0_r_en;
    logic               p0_w_en;
    logic [RDATA_W-1:0] p0_rdata;
    logic               p0_ready;

    logic [ADDR_W-1:0]  p1_address;
    logic [WDATA_W-1:0] p1_wdata;
    logic               p1_r_en;
    logic               p1_w_en;
    logic [RDATA_W-1:0] p1_rdata;
    logic               p1_ready;

    logic [ADDR_W-1:0]  sram_address;
    logic [WDATA_W-1:0] sram_wdata;
    logic               sram_r_en;
    logic               sram_w_en;
    logic [RDATA_W-1:0] sram_rdata;
    logic               sram_ready;

    // Arbiter side
    modport slave (
        input  p0_address, p0_wdata, p0_r_en, p0_w_en,
        output p0_rdata, p0_ready,
        input  p1_address, p1_wdata, p1_r_en, p1_w_en,
        output p1_rdata, p1_ready,
        output sram_address, sram_wdata, sram_r_en, sram_w_en,
        input  sram_rdata, sram_ready
    );

    // Requester / SRAM-controller side
    modport master (
        output p0_address, p0_wdata, p0_r_en, p0_w_en,
        input  p0_rdata, p0_ready,
        output p1_address, p1_wdata, p1_r_en, p1_w_en,
        input  p1_rdata, p1_ready,
        input  sram_address, sram_wdata, sram_r_en, sram_w_en,
        output sram_rdata, sram_ready
    );

endinterface

// File: rtl/sram_arb_grant.sv
// Two-way grant decision. SRAM_ARB_ROUND_ROBIN_EN: a tie goes to the port not granted last;
// otherwise port 0 wins every tie.
module sram_arb_grant (
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic grant_idx,
    output logic grant_valid
);

    logic tie_pick;

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    assign tie_pick = ~last_grant;
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;
    assign tie_pick          = 1'b0;
`endif

    assign grant_valid = req0 | req1;

    always_comb begin
        grant_idx = 1'b0;
        if (req0 && req1) begin
            grant_idx = tie_pick;
        end else begin
            grant_idx = req1;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Two-port arbiter in front of a single SRAM controller; one transaction in flight at a time.
// Build option SRAM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking instead of fixed priority.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   IDLE    | no access in flight; grant a requester and issue command
//   BUSY    | command held on sram_*; waiting for sram_ready
//   RELEASE | completion cycle; owner's ready pulses, back to IDLE
module sram_arbiter
    import sram_arbiter_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEFAULT,
    parameter int WDATA_W = WDATA_W_DEFAULT,
    parameter int RDATA_W = RDATA_W_DEFAULT
) (
    input  logic          clk,
    input  logic          rst,
    sram_arbiter_if.slave bus
);

    state_t state_q;
    state_t state_d;

    logic               owner_q;
    logic               last_grant;
    logic               req0;
    logic               req1;
    logic               grant_idx;
    logic               grant_valid;
    logic               sel_write;
    logic               issue;
    logic               complete;
    logic               in_release;

    logic [ADDR_W-1:0]  addr_q;
    logic [WDATA_W-1:0] wdata_q;
    logic               r_en_q;
    logic               w_en_q;
    logic [RDATA_W-1:0] p0_rdata_q;
    logic [RDATA_W-1:0] p1_rdata_q;

    assign req0 = bus.p0_r_en | bus.p0_w_en;
    assign req1 = bus.p1_r_en | bus.p1_w_en;

    sram_arb_grant u_grant (
        .req0        (req0),
        .req1        (req1),
        .last_grant  (last_grant),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

`ifdef SRAM_ARB_ROUND_ROBIN_EN
    logic last_q;

    // Resets to 1 so that port 0 takes the first tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_q <= 1'b1;
        end else if (issue) begin
            last_q <= grant_idx;
        end
    end

    assign last_grant = last_q;
`else
    assign last_grant = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (grant_valid) state_d = BUSY;
            BUSY:    if (bus.sram_ready) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        issue      = 1'b0;
        complete   = 1'b0;
        in_release = 1'b0;
        case (state_q)
            IDLE:    issue      = grant_valid;
            BUSY:    complete   = bus.sram_ready;
            RELEASE: in_release = 1'b1;
            default: ;
        endcase
    end

    // A port raising r_en and w_en together is serviced as a write.
    assign sel_write = grant_idx ? bus.p1_w_en : bus.p0_w_en;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_q    <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            r_en_q     <= 1'b0;
            w_en_q     <= 1'b0;
            p0_rdata_q <= '0;
            p1_rdata_q <= '0;
        end else if (issue) begin
            owner_q <= grant_idx;
            addr_q  <= grant_idx ? bus.p1_address : bus.p0_address;
            wdata_q <= grant_idx ? bus.p1_wdata : bus.p0_wdata;
            w_en_q  <= sel_write;
            r_en_q  <= ~sel_write;
        end else if (complete) begin
            r_en_q <= 1'b0;
            w_en_q <= 1'b0;
            // Read data lands even if the requester has already dropped its enable.
            if (r_en_q) begin
                if (owner_q) begin
                    p1_rdata_q <= bus.sram_rdata;
                end else begin
                    p0_rdata_q <= bus.sram_rdata;
                end
            end
        end
    end

    assign bus.sram_address = addr_q;
    assign bus.sram_wdata   = wdata_q;
    assign bus.sram_r_en    = r_en_q;
    assign bus.sram_w_en    = w_en_q;
    assign bus.p0_rdata     = p0_rdata_q;
    assign bus.p1_rdata     = p1_rdata_q;

    assign bus.p0_ready = (in_release && !owner_q) || !req0;
    assign bus.p1_ready = (in_release &&  owner_q) || !req1;

endmodule
